// File: rtl/uart_rx_module.sv
// -----------------------------------------------------------------------------
// uart_rx_module
// 8N1 UART receiver. The asynchronous rx line is synchronised and
// edge-detected. A local baud counter restarts on each accepted start edge.
// Each bit is sampled at mid-period. A good frame updates rx_data and pulses
// rx_done_sig for one cycle. A low stop bit pulses frame_err_sig for one cycle.
//
// Optional build macro: RX_MAJORITY_EN
//   Defined   : each bit is a 3-sample majority vote taken at BPS_HALF-1,
//               BPS_HALF and BPS_HALF+1. The decision is made at BPS_HALF+1.
//   Undefined : each bit is a single sample taken at BPS_HALF.
//
// Parameters:
//   BPS_DIV       sysclk cycles per bit (minimum 8)
//   BPS_HALF      mid-bit sample index within a bit period
//
// Ports:
//   sysclk        system clock; all logic runs on the rising edge
//   rst_n         asynchronous active-low reset
//   rx            serial line; idles high; asynchronous to sysclk
//   rx_en_sig     receive enable; 0 ignores the line and aborts any frame
//   rx_data       last good byte; LSB is the first data bit received
//   rx_done_sig   one-cycle pulse: rx_data was just updated
//   frame_err_sig one-cycle pulse: the stop bit was sampled low
//   rx_busy       high from start-edge detection until the return to idle
// -----------------------------------------------------------------------------
module uart_rx_module #(
    parameter int BPS_DIV  = 5208,
    parameter int BPS_HALF = BPS_DIV / 2
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_en_sig,
    output logic [7:0] rx_data,
    output logic       rx_done_sig,
    output logic       frame_err_sig,
    output logic       rx_busy
);

    localparam int CNT_W = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BPS_LAST  = CNT_W'(BPS_DIV - 1);
`ifdef RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] SAMPLE_A  = CNT_W'(BPS_HALF - 1);
    localparam logic [CNT_W-1:0] SAMPLE_B  = CNT_W'(BPS_HALF);
    localparam logic [CNT_W-1:0] DECIDE_PT = CNT_W'(BPS_HALF + 1);
`else
    localparam logic [CNT_W-1:0] DECIDE_PT = CNT_W'(BPS_HALF);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Two-of-three majority vote used for noise-tolerant bit decisions.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] bps_cnt_r, bps_cnt_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic [7:0]       rx_data_r, rx_data_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic             busy_r;
    logic             rx_meta_r, rx_sync_r, rx_prev_r;
    logic [1:0]       fill_r;
    logic             fall_s;
    logic             strobe_s;
    logic             bit_val_s;

    // A start edge only counts once the whole sync chain holds real line
    // samples. Otherwise the reset value of 1 would turn a line that is
    // already low at reset release into a false falling edge.
    assign fall_s   = (fill_r == 2'd3) && rx_prev_r && !rx_sync_r;
    assign strobe_s = (state_r != ST_IDLE) && (bps_cnt_r == DECIDE_PT);

`ifdef RX_MAJORITY_EN
    logic samp_a_r, samp_b_r;

    // Capture the two early votes that precede the decision point.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a_r <= 1'b1;
            samp_b_r <= 1'b1;
        end else begin
            if (bps_cnt_r == SAMPLE_A) begin
                samp_a_r <= rx_sync_r;
            end else begin
                samp_a_r <= samp_a_r;
            end
            if (bps_cnt_r == SAMPLE_B) begin
                samp_b_r <= rx_sync_r;
            end else begin
                samp_b_r <= samp_b_r;
            end
        end
    end

    assign bit_val_s = maj3(samp_a_r, samp_b_r, rx_sync_r);
`else
    assign bit_val_s = rx_sync_r;
`endif

    // Two-flop synchroniser, edge-detect flop, and post-reset fill tracker.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
            fill_r    <= 2'd0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            if (fill_r != 2'd3) begin
                fill_r <= fill_r + 2'd1;
            end else begin
                fill_r <= fill_r;
            end
        end
    end

    // Next-state, counter, shift register and output pulse decode.
    always_comb begin
        state_s   = state_r;
        bps_cnt_s = CNT_ZERO;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        rx_data_s = rx_data_r;
        done_s    = 1'b0;
        err_s     = 1'b0;

        if (state_r == ST_IDLE) begin
            bps_cnt_s = CNT_ZERO;
        end else if (bps_cnt_r == BPS_LAST) begin
            bps_cnt_s = CNT_ZERO;
        end else begin
            bps_cnt_s = bps_cnt_r + CNT_ONE;
        end

        case (state_r)
            ST_IDLE: begin
                if (rx_en_sig && fall_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!rx_en_sig) begin
                    state_s   = ST_IDLE;
                    bps_cnt_s = CNT_ZERO;
                end else if (strobe_s) begin
                    if (bit_val_s) begin
                        // Line was high again at mid-start: treat as a glitch.
                        state_s   = ST_IDLE;
                        bps_cnt_s = CNT_ZERO;
                    end else begin
                        state_s   = ST_DATA;
                        bit_cnt_s = 3'd0;
                    end
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (!rx_en_sig) begin
                    state_s   = ST_IDLE;
                    bps_cnt_s = CNT_ZERO;
                end else if (strobe_s) begin
                    // Shift in from the top so the first bit ends in bit 0.
                    shift_s = {bit_val_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_s   = ST_STOP;
                        bit_cnt_s = 3'd0;
                    end else begin
                        state_s   = ST_DATA;
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (!rx_en_sig) begin
                    state_s   = ST_IDLE;
                    bps_cnt_s = CNT_ZERO;
                end else if (strobe_s) begin
                    // Return to idle at mid-stop so back-to-back frames work.
                    state_s   = ST_IDLE;
                    bps_cnt_s = CNT_ZERO;
                    if (bit_val_s) begin
                        rx_data_s = shift_r;
                        done_s    = 1'b1;
                    end else begin
                        err_s     = 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                bps_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // State register plus all registered datapath and outputs.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bps_cnt_r <= CNT_ZERO;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            rx_data_r <= 8'h00;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bps_cnt_r <= bps_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            rx_data_r <= rx_data_s;
            done_r    <= done_s;
            err_r     <= err_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign rx_data       = rx_data_r;
    assign rx_done_sig   = done_r;
    assign frame_err_sig = err_r;
    assign rx_busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_module.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_module
// Directed-stimulus scoreboard bench for uart_rx_module with BPS_DIV=16.
// The stimulus pushes the expected byte or frame error into a queue. A monitor
// pops an entry and compares it whenever rx_done_sig or frame_err_sig pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx_module;

    localparam int BPS  = 16;
    localparam int HALF = BPS / 2;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       sysclk;
    logic       rst_n;
    logic       rx;
    logic       rx_en_sig;
    logic [7:0] rx_data;
    logic       rx_done_sig;
    logic       frame_err_sig;
    logic       rx_busy;

    exp_t exp_q[$];
    int   done_cyc_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mon_cyc = 0;
    logic prev_pulse = 1'b0;
    logic busy_mid = 1'b0;

    uart_rx_module #(.BPS_DIV(BPS), .BPS_HALF(HALF)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_en_sig    (rx_en_sig),
        .rx_data      (rx_data),
        .rx_done_sig  (rx_done_sig),
        .frame_err_sig(frame_err_sig),
        .rx_busy      (rx_busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Drives one 8N1 frame, LSB first. If spike_bit is between 0 and 7, that
    // data bit carries a one-cycle inverted spike at its mid-point.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int spike_bit);
        rx = 1'b0;
        idle(BPS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == spike_bit) begin
                idle(HALF);
                rx = ~data[i];
                idle(1);
                rx = data[i];
                idle(BPS - HALF - 1);
            end else begin
                idle(BPS);
            end
            if (i == 4) busy_mid = rx_busy;
        end
        rx = stop_bit;
        idle(BPS);
        rx = 1'b1;
    endtask

    // Scoreboard monitor: each output pulse pops and checks one expectation.
    always @(negedge sysclk) begin
        mon_cyc = mon_cyc + 1;
        if (rst_n) begin
            if (rx_done_sig && frame_err_sig) begin
                n_tests++; n_fail++;
                $display("FAIL pulse_excl: done=%0b err=%0b, expected not both", rx_done_sig, frame_err_sig);
            end
            if ((rx_done_sig || frame_err_sig) && prev_pulse) begin
                n_tests++; n_fail++;
                $display("FAIL pulse_width: pulse on consecutive cycles at cycle %0d", mon_cyc);
            end
            if (rx_done_sig || frame_err_sig) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b data=0x%0h, expected no pulse",
                             rx_done_sig, frame_err_sig, rx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_tests++;
                    if ((frame_err_sig !== e.is_err) || (rx_data !== e.data)) begin
                        n_fail++;
                        $display("FAIL scoreboard: err=%0b data=0x%0h, expected err=%0b data=0x%0h",
                                 frame_err_sig, rx_data, e.is_err, e.data);
                    end
                end
                if (rx_done_sig) done_cyc_q.push_back(mon_cyc);
            end
            prev_pulse = rx_done_sig | frame_err_sig;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        rst_n     = 1'b0;
        rx        = 1'b1;
        rx_en_sig = 1'b1;
        idle(3);
        check("rst_data",  {24'd0, rx_data}, 32'h00);
        check("rst_done",  {31'd0, rx_done_sig}, 32'd0);
        check("rst_err",   {31'd0, frame_err_sig}, 32'd0);
        check("rst_busy",  {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // A single good frame.
        exp_q.push_back('{1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, -1);
        check("t1_busy_mid",   {31'd0, busy_mid}, 32'd1);
        check("t1_busy_after", {31'd0, rx_busy}, 32'd0);
        check("t1_data",       {24'd0, rx_data}, 32'hA5);
        idle(4);

        // Back-to-back frames with no idle gap.
        done_cyc_q.delete();
        exp_q.push_back('{1'b0, 8'h00});
        exp_q.push_back('{1'b0, 8'hFF});
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        idle(4);
        check("t2_done_count", done_cyc_q.size(), 32'd2);
        if (done_cyc_q.size() == 2) begin
            int gap;
            gap = done_cyc_q[1] - done_cyc_q[0];
            check("t2_gap_in_range", {31'd0, (gap >= 158 && gap <= 162)}, 32'd1);
        end

        // The stop bit is held low, so a framing error is expected.
        exp_q.push_back('{1'b1, 8'hFF});
        send_frame(8'h3C, 1'b0, -1);
        idle(20);
        check("t3_data_kept", {24'd0, rx_data}, 32'hFF);

        // A short low glitch gives a false start.
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(2);
        check("t4_busy_in_start", {31'd0, rx_busy}, 32'd1);
        idle(20);
        check("t4_busy_idle", {31'd0, rx_busy}, 32'd0);
        exp_q.push_back('{1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1, -1);
        idle(4);

        // Receive is disabled during data bit 4 of 0x81.
        rx = 1'b0;
        idle(BPS);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            idle(BPS);
        end
        rx = 1'b0;
        idle(5);
        check("t5_busy_before", {31'd0, rx_busy}, 32'd1);
        rx_en_sig = 1'b0;
        idle(2);
        check("t5_busy_abort", {31'd0, rx_busy}, 32'd0);
        idle(BPS);
        rx = 1'b1;
        idle(4 * BPS);
        check("t5_data_kept", {24'd0, rx_data}, 32'h5A);
        rx_en_sig = 1'b1;
        idle(10);
        exp_q.push_back('{1'b0, 8'h81});
        send_frame(8'h81, 1'b1, -1);
        idle(4);
        check("t5_data", {24'd0, rx_data}, 32'h81);

`ifdef RX_MAJORITY_EN
        // A one-cycle low spike in a 1 bit is voted out.
        exp_q.push_back('{1'b0, 8'hFF});
        send_frame(8'hFF, 1'b1, 3);
        idle(4);
        check("t6_spike_data", {24'd0, rx_data}, 32'hFF);
`endif

        // Reset is asserted mid-frame while the line stays low through release.
        rx = 1'b0;
        idle(3 * BPS + 5);
        check("t6_busy_pre_rst", {31'd0, rx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", {24'd0, rx_data}, 32'h00);
        check("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("t6_rst_pulses", {30'd0, rx_done_sig, frame_err_sig}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(5 * BPS);
        check("t6_no_false_start", {31'd0, rx_busy}, 32'd0);
        rx = 1'b1;
        idle(3 * BPS);
        check("t6_data_after", {24'd0, rx_data}, 32'h00);

        // The receiver recovers and takes a clean frame after the reset.
        exp_q.push_back('{1'b0, 8'hC3});
        send_frame(8'hC3, 1'b1, -1);
        idle(10);
        check("t6_recover_data", {24'd0, rx_data}, 32'hC3);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_module.md
Name: uart_rx_module

Overview:
UART receiver that pairs with the existing 8N1 transmitter in the serial test design. It synchronises the asynchronous rx line and runs its own baud counter, restarted on each start-bit edge. It samples each bit at mid-period and delivers one byte per frame to downstream logic with a one-cycle done pulse. It also flags framing errors.

Parameters:
BPS_DIV, 5208, sysclk cycles per bit (50 MHz / 9600 baud); minimum 8
BPS_HALF, BPS_DIV/2, sample point within a bit period (cycle index of mid-bit)

Ports:
sysclk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to sysclk
rx_en_sig  input  1  receive enable; 0 = ignore line / abort frame
rx_data  output  8  last good byte, LSB = first data bit received
rx_done_sig  output  1  one-cycle pulse: rx_data just updated
frame_err_sig  output  1  one-cycle pulse: stop bit sampled low
rx_busy  output  1  high from start edge detection until return to IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, rx_data=8'h00, rx_done_sig=0, frame_err_sig=0, rx_busy=0, sync flops=1, bps_cnt=0, bit_cnt=0.
- Input sync: 2-flop synchroniser plus a third flop for edge detect. rx_s is the synchronised value. fall = prev 1 and rx_s 0. Line-to-detect latency is 3 cycles.
- bps_cnt: counts 0..BPS_DIV-1 and wraps while state is not IDLE. It is cleared to 0 in IDLE. A sample strobe fires when bps_cnt==BPS_HALF.
- IDLE: if rx_en_sig=1 and fall, go to START with rx_busy=1. A fall while rx_en_sig=0 is ignored.
- START: at the strobe, if rx_s=0 go to DATA with bit_cnt=0. If rx_s=1 (glitch or false start), return to IDLE with no pulse.
- DATA: at each strobe, shift rx_s into the shift register MSB-first into position so the first bit lands in bit 0, and increment bit_cnt. After the 8th sample, go to STOP.
- STOP: at the strobe:
  - rx_s=1: rx_data <= shift register and rx_done_sig=1 for exactly the next cycle.
  - rx_s=0: frame_err_sig=1 for the next cycle; rx_data keeps its previous value.
  - Either way, return to IDLE on the same edge, so the next start edge can be accepted at mid-stop (back-to-back frames).
- Latency: rx_done_sig rises 1 cycle after the stop-bit strobe. rx_data is stable from that cycle until the next good frame.
- rx_done_sig and frame_err_sig are mutually exclusive and never asserted for two consecutive cycles.
- rx_en_sig dropping to 0 in any non-IDLE state: return to IDLE on the next edge, no pulses, rx_data unchanged, bps_cnt cleared.
- Reset asserted mid-frame: all state clears immediately. The partial frame is discarded. After release, a new start edge is required; a line already low at release is not treated as a start.
- bit_cnt is 3 bits plus terminal detect; bps_cnt is sized to hold BPS_DIV-1.

Optional Feature:
Macro RX_MAJORITY_EN.
- Defined: each bit decision is the majority vote of rx_s sampled at BPS_HALF-1, BPS_HALF and BPS_HALF+1, registered, with the decision taken at BPS_HALF+1. START, DATA and STOP all use the voted value. The done/err pulses shift 1 cycle later.
- Undefined: a single sample at BPS_HALF.
- Ports and all other behaviour are identical in both builds.

Test Plan:
1. BPS_DIV=16, rx_en_sig=1, send 8N1 byte 8'hA5 -> one rx_done_sig pulse, rx_data=8'hA5, frame_err_sig never high, rx_busy low after the stop midpoint.
2. Back-to-back 8'h00 then 8'hFF, zero idle gap -> two rx_done_sig pulses 160 cycles apart (±2), rx_data=8'h00 then 8'hFF.
3. Send 8'h3C with the stop bit forced low -> frame_err_sig pulse once, no rx_done_sig, rx_data keeps its prior value 8'hFF.
4. rx low for 4 cycles, then high (glitch) -> state returns to IDLE at the START strobe, no pulses; a following 8'h5A frame is received correctly.
5. Deassert rx_en_sig during data bit 4 of 8'h81 -> no pulse, rx_busy low within 1 cycle; re-enable, send 8'h81 -> rx_data=8'h81.
6. Assert rst_n=0 mid-frame for 3 cycles -> all outputs 0 immediately. With RX_MAJORITY_EN defined, a one-cycle low spike at BPS_HALF of a 1 bit in 8'hFF still yields rx_data=8'hFF.
